decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   Instruction decode stage of the word-addressed 5-stage pipeline, directly downstream of fetch.
//   - Consumes the fetch outputs IR/NPC.
//   - Holds the 32-entry register file and reads operands.
//   - Sign-extends the immediate, classifies the instruction and computes the branch target.
//   - Registers everything into the ID/EX pipeline register consumed by execute.
//   - Execute returns cond and RPC (= id_tgt) to fetch.
//   - Writeback writes the register file through a dedicated port.
// PARAMETERS
//   XLEN   32  datapath / register width
//   NREG   32  number of architectural registers (r0 hardwired to zero)
//   AW     5   register index width, log2(NREG)
// PORTS
//   clk       in   1     clock, all state updates on posedge
//   reset     in   1     synchronous, active-high
//   ir        in   32    instruction from fetch (32'h0 = NOP/bubble)
//   npc       in   32    PC+1 of ir, from fetch
//   flush     in   1     squash instruction entering ID/EX this edge (taken branch resolved in EX)
//   stall     in   1     hold ID/EX contents this edge (EX busy)
//   wb_en     in   1     writeback enable
//   wb_addr   in   AW    writeback register index
//   wb_data   in   XLEN  writeback data
//   id_ir     out  32    latched instruction
//   id_npc    out  32    latched NPC
//   id_a      out  XLEN  operand A = R[ir[20:16]]
//   id_b      out  XLEN  operand B: R[ir[25:21]] for store, else R[ir[15:11]]
//   id_imm    out  XLEN  sign-extended ir[15:0]
//   id_tgt    out  32    branch target npc + id_imm (32-bit, wraps mod 2^32)
//   id_rd     out  AW    destination index ir[25:21] (0 when no writeback)
//   id_we     out  1     instruction writes a register
//   id_is_alu out  1     ir[31:30]==2'b00 and ir!=0
//   id_is_ld  out  1     ir[31:26]==6'b010001
//   id_is_st  out  1     ir[31:26]==6'b010000
//   id_is_br  out  1     ir[31:30]==2'b10 (branch on id_a==0)
//   bubbles   out  16    count of squashed/NOP slots latched, saturating at 16'hFFFF
// BEHAVIOUR
//   Reset:
//   - All ID/EX outputs and bubbles are 0.
//   - All NREG registers are 0.
//   - Reset overrides flush, stall and wb_en in the same cycle.
//   Priority per edge: reset > flush > stall > normal latch.
//   Latency:
//   - Exactly 1 cycle from ir/npc to id_* outputs.
//   - No combinational path from inputs to outputs.
//   Flush:
//   - id_ir, id_rd, id_we, id_is_* and id_a/id_b/id_imm/id_tgt/id_npc are all loaded with 0.
//   - bubbles increments.
//   - Flush wins over a simultaneous stall.
//   Stall:
//   - All id_* outputs hold their value and bubbles holds.
//   - Register file writeback still occurs.
//   Normal latch:
//   - Decode of ir is captured.
//   - If ir==0, all class bits are 0, id_we=0 and bubbles increments.
//   id_we = id_is_alu | id_is_ld, and id_rd is non-zero.
//   - Stores, branches, NOPs and writes targeting r0 give id_we=0 and id_rd=0.
//   Register file:
//   - Written on posedge when wb_en && wb_addr!=0.
//   - Writes to r0 are ignored; reads of r0 always return 0.
//   - Write-through bypass: if wb_en && wb_addr!=0 and wb_addr equals a read index in the
//     same cycle, the operand latched is wb_data, not the stale entry.
//   bubbles saturates and never wraps.
//   Unknown opcodes (ir[31:30]==2'b11, or 01 other than ld/st) latch with all class bits 0
//   and id_we=0.
//   - These are treated as NOP but are not counted as bubbles.
// TESTING
//   - Reset: assert reset 2 cycles with wb_en=1 -> all id_* = 0, bubbles=0; then R1..R31 read 0.
//   - Writeback bypass: wb_en=1, wb_addr=3, wb_data=32'hDEADBEEF, ir = ALU with [20:16]=3 in
//     the same cycle -> id_a=32'hDEADBEEF next cycle.
//   - r0: wb to r0 with 32'h1234, then read r0 -> id_a=0; ALU with rd=0 -> id_we=0, id_rd=0.
//   - Store operand: R5=7, R6=9; store ir {6'b010000,5'd5,5'd6,16'hFFFE} -> id_b=7, id_a=9,
//     id_imm=32'hFFFFFFFE, id_is_st=1, id_we=0.
//   - Branch target: npc=32'h10, branch imm=16'hFFF0 -> id_tgt=32'h0; npc=32'hFFFFFFFF,
//     imm=1 -> id_tgt=0 (wrap).
//   - Flush/stall: stall=1 for 3 cycles -> outputs frozen while a wb still lands;
//     flush=1 && stall=1 -> id_ir=0, bubbles+1.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, operand read/bypass, decode and ID/EX register
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir,
  input  logic [31:0]     npc,
  input  logic            flush,
  input  logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [31:0]     id_ir,
  output logic [31:0]     id_npc,
  output logic [XLEN-1:0] id_a,
  output logic [XLEN-1:0] id_b,
  output logic [XLEN-1:0] id_imm,
  output logic [31:0]     id_tgt,
  output logic [AW-1:0]   id_rd,
  output logic            id_we,
  output logic            id_is_alu,
  output logic            id_is_ld,
  output logic            id_is_st,
  output logic            id_is_br,
  output logic [15:0]     bubbles
);
  logic [XLEN-1:0] rf [NREG];
  logic            is_nop, is_alu, is_ld, is_st, is_br, we, wb_hit;
  logic [AW-1:0]   ra, rb, rd;
  logic [XLEN-1:0] op_a, op_b, imm;
  logic [15:0]     bub_nx;

  assign is_nop = ir == 32'h0;
  assign is_alu = ir[31:30] == 2'b00 && !is_nop;
  assign is_ld  = ir[31:26] == 6'b010001;
  assign is_st  = ir[31:26] == 6'b010000;
  assign is_br  = ir[31:30] == 2'b10;
  assign rd     = ir[25:21];
  assign we     = (is_alu || is_ld) && rd != '0;
  assign ra     = ir[20:16];
  assign rb     = is_st ? ir[25:21] : ir[15:11];
  assign imm    = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign wb_hit = wb_en && wb_addr != '0;
  assign bub_nx = bubbles == 16'hFFFF ? bubbles : bubbles + 16'd1;

  // Operand read: r0 reads zero, a same-cycle writeback to the index bypasses the array
  always_comb begin
    op_a = ra == '0 ? '0 : (wb_hit && wb_addr == ra) ? wb_data : rf[ra];
    op_b = rb == '0 ? '0 : (wb_hit && wb_addr == rb) ? wb_data : rf[rb];
  end

  // Register file: cleared by reset, written by writeback except to r0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ID/EX register: reset > flush (zero slot, count bubble) > stall (hold) > latch decode
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      id_ir     <= '0;
      id_npc    <= '0;
      id_a      <= '0;
      id_b      <= '0;
      id_imm    <= '0;
      id_tgt    <= '0;
      id_rd     <= '0;
      id_we     <= 1'b0;
      id_is_alu <= 1'b0;
      id_is_ld  <= 1'b0;
      id_is_st  <= 1'b0;
      id_is_br  <= 1'b0;
      bubbles   <= reset ? 16'h0 : bub_nx;
    end else if (!stall) begin
      id_ir     <= ir;
      id_npc    <= npc;
      id_a      <= op_a;
      id_b      <= op_b;
      id_imm    <= imm;
      id_tgt    <= npc + imm[31:0];
      id_rd     <= we ? rd : '0;
      id_we     <= we;
      id_is_alu <= is_alu;
      id_is_ld  <= is_ld;
      id_is_st  <= is_st;
      id_is_br  <= is_br;
      if (is_nop) bubbles <= bub_nx;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus, per-cycle model comparison plus literal spot checks
module tb_decode_stage;
  logic        clk = 0, reset, flush, stall, wb_en;
  logic [31:0] ir, npc, wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] id_ir, id_npc, id_a, id_b, id_imm, id_tgt;
  logic [4:0]  id_rd;
  logic        id_we, id_is_alu, id_is_ld, id_is_st, id_is_br;
  logic [15:0] bubbles;
  int          n_chk = 0, n_fail = 0;
  bit          chk = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .ir(ir), .npc(npc), .flush(flush), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_ir(id_ir), .id_npc(id_npc), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_tgt(id_tgt), .id_rd(id_rd), .id_we(id_we), .id_is_alu(id_is_alu),
    .id_is_ld(id_is_ld), .id_is_st(id_is_st), .id_is_br(id_is_br), .bubbles(bubbles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, npc, a, b, imm, tgt;
    logic [4:0]  rd;
    logic        we, alu, ld, st, br;
    int          bub;
  } exp_t;

  exp_t        e;
  logic [31:0] mreg [32];

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_reg(logic [4:0] idx);
    if (idx == 0) return 0;
    if (wb_en && wb_addr == idx) return wb_data;
    return mreg[idx];
  endfunction

  function automatic exp_t zero_slot(int bub);
    exp_t z;
    z = '{ir:0, npc:0, a:0, b:0, imm:0, tgt:0, rd:0, we:0, alu:0, ld:0, st:0, br:0, bub:bub};
    return z;
  endfunction

  // Model: instruction classes and operand rules applied directly to the fetched word
  always @(posedge clk) begin
    if (reset) begin
      e = zero_slot(0);
      foreach (mreg[i]) mreg[i] = 0;
      chk = 1;
    end else begin
      if (flush) e = zero_slot(e.bub < 65535 ? e.bub + 1 : e.bub);
      else if (!stall) begin
        e.ir  = ir;
        e.npc = npc;
        e.alu = ir != 0 && ir[31:30] == 2'b00;
        e.ld  = ir[31:26] == 6'b010001;
        e.st  = ir[31:26] == 6'b010000;
        e.br  = ir[31:30] == 2'b10;
        e.imm = 32'($signed(ir[15:0]));
        e.tgt = npc + e.imm;
        e.a   = rd_reg(ir[20:16]);
        e.b   = e.st ? rd_reg(ir[25:21]) : rd_reg(ir[15:11]);
        e.we  = (e.alu || e.ld) && ir[25:21] != 0;
        e.rd  = e.we ? ir[25:21] : 5'd0;
        if (ir == 0 && e.bub < 65535) e.bub++;
      end
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
    end
  end

  // Compare every cycle once reset has been seen
  always @(negedge clk) begin
    if (chk) begin
      check("m_ir", id_ir, e.ir);
      check("m_npc", id_npc, e.npc);
      check("m_a", id_a, e.a);
      check("m_b", id_b, e.b);
      check("m_imm", id_imm, e.imm);
      check("m_tgt", id_tgt, e.tgt);
      check("m_rd", {27'b0, id_rd}, {27'b0, e.rd});
      check("m_flags", {27'b0, id_we, id_is_alu, id_is_ld, id_is_st, id_is_br},
            {27'b0, e.we, e.alu, e.ld, e.st, e.br});
      check("m_bubbles", {16'b0, bubbles}, 32'(e.bub));
    end
  end

  function automatic logic [31:0] alu(logic [4:0] rd, logic [4:0] ra, logic [4:0] rb);
    return {6'b000001, rd, ra, rb, 11'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] ld_ir;

  initial begin
    reset = 1; flush = 1; stall = 1; wb_en = 1; wb_addr = 5; wb_data = 32'hFF;
    ir = alu(1, 2, 3); npc = 5;
    step(); step();
    check("rst_ir", id_ir, 0);
    check("rst_a", id_a, 0);
    check("rst_we", {31'b0, id_we}, 0);
    check("rst_bubbles", {16'b0, bubbles}, 0);
    reset = 0; flush = 0; stall = 0; wb_en = 0;
    for (int i = 1; i < 32; i++) begin
      ir = alu(1, 5'(i), 5'(i));
      step();
      check("rst_reg_a", id_a, 0);
      check("rst_reg_b", id_b, 0);
    end
    wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF; ir = alu(1, 3, 0);
    step();
    check("bypass_a", id_a, 32'hDEADBEEF);
    wb_addr = 0; wb_data = 32'h1234; ir = alu(1, 0, 0);
    step();
    check("r0_read", id_a, 0);
    wb_en = 0; ir = alu(0, 3, 3);
    step();
    check("r0_we", {31'b0, id_we}, 0);
    check("r0_rd", {27'b0, id_rd}, 0);
    check("r3_kept", id_a, 32'hDEADBEEF);
    wb_en = 1; wb_addr = 5; wb_data = 7; ir = alu(1, 0, 0);
    step();
    wb_addr = 6; wb_data = 9;
    step();
    wb_en = 0; ir = {6'b010000, 5'd5, 5'd6, 16'hFFFE};
    step();
    check("st_b", id_b, 7);
    check("st_a", id_a, 9);
    check("st_imm", id_imm, 32'hFFFFFFFE);
    check("st_cls", {31'b0, id_is_st}, 1);
    check("st_we", {31'b0, id_we}, 0);
    npc = 32'h10; ir = {6'b100000, 5'd0, 5'd0, 16'hFFF0};
    step();
    check("br_tgt", id_tgt, 0);
    check("br_cls", {31'b0, id_is_br}, 1);
    npc = 32'hFFFFFFFF; ir = {6'b100000, 5'd0, 5'd0, 16'h0001};
    step();
    check("br_wrap", id_tgt, 0);
    ld_ir = {6'b010001, 5'd2, 5'd3, 16'h0004}; npc = 32'h20; ir = ld_ir;
    step();
    check("ld_we", {31'b0, id_we}, 1);
    check("ld_rd", {27'b0, id_rd}, 2);
    check("ld_a", id_a, 32'hDEADBEEF);
    check("ld_tgt", id_tgt, 32'h24);
    ir = {6'b110000, 5'd2, 5'd3, 16'h0};
    step();
    check("unk_flags", {27'b0, id_we, id_is_alu, id_is_ld, id_is_st, id_is_br}, 0);
    ir = {6'b011111, 5'd2, 5'd3, 16'h0};
    step();
    check("unk_rd", {27'b0, id_rd}, 0);
    check("unk_bubbles", {16'b0, bubbles}, 0);
    ir = ld_ir;
    step();
    stall = 1; wb_en = 1; wb_addr = 7; wb_data = 55; ir = alu(1, 7, 7);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ir", id_ir, ld_ir);
    end
    stall = 0; wb_en = 0;
    step();
    check("stall_wb", id_a, 55);
    flush = 1; stall = 1;
    step();
    check("flush_ir", id_ir, 0);
    check("flush_bubbles", {16'b0, bubbles}, 1);
    flush = 0; stall = 0; ir = 0;
    step();
    check("nop_bubbles", {16'b0, bubbles}, 2);
    check("nop_we", {31'b0, id_we}, 0);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
